// File: rtl/debounced_enable_gen_pkg.sv
// Shared definitions for the debounced enable generator: FSM state encoding
// and the constant helpers used to size the debounce counter.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic int cnt_width(input int cycles);
    return (clog2(cycles) < 1) ? 1 : clog2(cycles);
  endfunction

endpackage

// File: rtl/debounced_enable_gen_if.sv
// Signal bundle between the bouncy source, the debouncer and the downstream
// counter enable.
interface debounced_enable_gen_if;

  logic raw_in;
  logic enable_pulse;
  logic level_out;
  logic busy;

  modport master (
    output raw_in,
    input  enable_pulse,
    input  level_out,
    input  busy
  );

  modport slave (
    input  raw_in,
    output enable_pulse,
    output level_out,
    output busy
  );

endinterface

// File: rtl/debounced_enable_gen_bit_synchronizer.sv
// Multi-flop synchroniser bringing an asynchronous bit into the clock domain;
// cleared to 0 on reset.
module bit_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would collapse the chain into one flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounced_enable_gen.sv
// Synchronises and debounces a bouncy input, emitting one registered enable
// pulse per accepted press for the downstream up-counter.
module debounced_enable_gen
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic                   clock,
  input logic                   reset,
  debounced_enable_gen_if.slave bus
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;
  logic             busy_q, busy_d;

  bit_synchronizer #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.raw_in),
    .q     (s)
  );

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A high sample here is release bounce: back to HELD without a pulse.
        if (s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    busy_d  = (state_d == PRESS_WAIT) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.enable_pulse = pulse_q;
  assign bus.level_out    = level_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_debounced_enable_gen.sv
// Directed bench for debounced_enable_gen with default parameters (2, 16);
// includes a 4-bit downstream counter fed by enable_pulse.
module tb_debounced_enable_gen;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_fail;
  int   pulse_cnt;
  int   base;
  logic [3:0] dn_ctr;

  debounced_enable_gen_if bus ();

  debounced_enable_gen #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.enable_pulse === 1'b1) pulse_cnt = pulse_cnt + 1;
  end

  always @(posedge clock or posedge reset) begin
    if (reset) dn_ctr <= 4'd0;
    else if (bus.enable_pulse === 1'b1) dn_ctr <= dn_ctr + 4'd1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp = n_cmp + 1;
    assert (observed === expected) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    pulse_cnt  = 0;
    reset      = 1'b1;
    bus.raw_in = 1'b1;

    // Reset held with raw_in high: outputs low, first pulse at edge 19 after release.
    tick(3);
    check("rst_pulse", 32'(bus.enable_pulse), 32'd0);
    check("rst_level", 32'(bus.level_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    tick(2);
    check("rst_e2_busy", 32'(bus.busy), 32'd0);
    tick(1);
    check("rst_e3_busy", 32'(bus.busy), 32'd1);
    tick(15);
    check("rst_e18_pulse", 32'(bus.enable_pulse), 32'd0);
    check("rst_e18_level", 32'(bus.level_out), 32'd0);
    tick(1);
    check("rst_e19_pulse", 32'(bus.enable_pulse), 32'd1);
    check("rst_e19_level", 32'(bus.level_out), 32'd1);
    check("rst_e19_busy", 32'(bus.busy), 32'd0);
    tick(1);
    check("rst_e20_pulse", 32'(bus.enable_pulse), 32'd0);
    tick(80);
    check("rst_hold_pulses", 32'(pulse_cnt), 32'd1);
    check("rst_hold_level", 32'(bus.level_out), 32'd1);

    // Clean release: level_out falls at edge 19, no pulse on release.
    bus.raw_in = 1'b0;
    tick(18);
    check("rel_e18_level", 32'(bus.level_out), 32'd1);
    check("rel_e18_busy", 32'(bus.busy), 32'd1);
    tick(1);
    check("rel_e19_level", 32'(bus.level_out), 32'd0);
    check("rel_e19_busy", 32'(bus.busy), 32'd0);
    check("rel_no_pulse", 32'(pulse_cnt), 32'd1);
    tick(5);

    // Clean press held 100 cycles.
    base       = pulse_cnt;
    bus.raw_in = 1'b1;
    tick(2);
    check("clean_e2_busy", 32'(bus.busy), 32'd0);
    tick(1);
    check("clean_e3_busy", 32'(bus.busy), 32'd1);
    tick(15);
    check("clean_e18_pulse", 32'(bus.enable_pulse), 32'd0);
    tick(1);
    check("clean_e19_pulse", 32'(bus.enable_pulse), 32'd1);
    check("clean_e19_level", 32'(bus.level_out), 32'd1);
    check("clean_e19_busy", 32'(bus.busy), 32'd0);
    tick(1);
    check("clean_e20_pulse", 32'(bus.enable_pulse), 32'd0);
    tick(80);
    check("clean_pulses", 32'(pulse_cnt - base), 32'd1);
    bus.raw_in = 1'b0;
    tick(25);
    check("clean_idle_level", 32'(bus.level_out), 32'd0);

    // Press bounce: high 5, low 3, high 5, low.
    base       = pulse_cnt;
    bus.raw_in = 1'b1;
    tick(5);
    check("pbounce_e5_busy", 32'(bus.busy), 32'd1);
    bus.raw_in = 1'b0;
    tick(3);
    check("pbounce_e8_busy", 32'(bus.busy), 32'd0);
    bus.raw_in = 1'b1;
    tick(5);
    bus.raw_in = 1'b0;
    tick(30);
    check("pbounce_pulses", 32'(pulse_cnt - base), 32'd0);
    check("pbounce_level", 32'(bus.level_out), 32'd0);
    check("pbounce_busy", 32'(bus.busy), 32'd0);

    // Release bounce: accepted press, then 1/0 every 3 cycles for 30 cycles.
    bus.raw_in = 1'b1;
    tick(25);
    check("rbounce_press", 32'(bus.level_out), 32'd1);
    base = pulse_cnt;
    for (int k = 0; k < 5; k++) begin
      bus.raw_in = 1'b0;
      tick(3);
      bus.raw_in = 1'b1;
      tick(3);
    end
    check("rbounce_level_hold", 32'(bus.level_out), 32'd1);
    bus.raw_in = 1'b0;
    tick(18);
    check("rbounce_e18_level", 32'(bus.level_out), 32'd1);
    tick(1);
    check("rbounce_e19_level", 32'(bus.level_out), 32'd0);
    check("rbounce_pulses", 32'(pulse_cnt - base), 32'd0);
    tick(5);

    // Reset in PRESS_WAIT: aborted, full sequence after release.
    base       = pulse_cnt;
    bus.raw_in = 1'b1;
    tick(10);
    reset = 1'b1;
    #1;
    check("rmid_busy", 32'(bus.busy), 32'd0);
    check("rmid_pulse", 32'(bus.enable_pulse), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(18);
    check("rmid_e18_pulse", 32'(bus.enable_pulse), 32'd0);
    check("rmid_e18_count", 32'(pulse_cnt - base), 32'd0);
    tick(1);
    check("rmid_e19_pulse", 32'(bus.enable_pulse), 32'd1);
    tick(20);
    check("rmid_count", 32'(pulse_cnt - base), 32'd1);
    bus.raw_in = 1'b0;
    tick(25);

    // Counter chain: five presses spaced 60 cycles.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("chain_ctr_start", 32'(dn_ctr), 32'd0);
    base = pulse_cnt;
    for (int k = 0; k < 5; k++) begin
      bus.raw_in = 1'b1;
      tick(30);
      bus.raw_in = 1'b0;
      tick(30);
    end
    check("chain_ctr", 32'(dn_ctr), 32'd5);
    check("chain_pulses", 32'(pulse_cnt - base), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/debounced_enable_gen.md
Name: debounced_enable_gen

Overview:
Upstream conditioning stage for the team's up-counter. It takes an asynchronous, bouncy input (push-button or external strobe), synchronises it to clock and debounces it. On each accepted press it emits a single-cycle enable pulse, which drives the downstream counter's enable input so the counter advances exactly once per physical event.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the synchroniser chain; legal range is 2 or more.
DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles required to accept a press or a release; legal range is 1 or more.
CNT_W, max(1, clog2(DEBOUNCE_CYCLES)), width of the debounce counter; derived, never overridden.

Ports:
clock  input  1  single system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset (posedge reset in the sensitivity list); clears all state immediately.
raw_in  input  1  asynchronous, possibly bouncing input; active-high.
enable_pulse  output  1  registered one-cycle pulse per accepted press; connects to the downstream counter's enable.
level_out  output  1  registered debounced level: 1 in HELD and RELEASE_WAIT, 0 otherwise.
busy  output  1  registered; 1 while in PRESS_WAIT or RELEASE_WAIT.

Behaviour:
- Reset (asynchronous, active-high):
  - Synchroniser chain is cleared to 0.
  - FSM goes to IDLE and the debounce counter to 0.
  - enable_pulse, level_out and busy go to 0 immediately, not at the next edge.
- Synchroniser: raw_in passes through SYNC_STAGES flip-flops. The last stage is `s`. A value held on raw_in before edge 1 appears on `s` after edge SYNC_STAGES.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. Transitions are evaluated on each clock edge:
  - IDLE: if s=1, go to PRESS_WAIT with cnt=0; otherwise stay.
  - PRESS_WAIT:
    - If s=0, return to IDLE with cnt=0 (bounce rejected, no pulse).
    - Else if cnt==DEBOUNCE_CYCLES-1, go to HELD and set enable_pulse=1.
    - Else cnt=cnt+1.
  - HELD: if s=0, go to RELEASE_WAIT with cnt=0; otherwise stay. No further pulses while held, for any hold duration.
  - RELEASE_WAIT:
    - If s=1, return to HELD with cnt=0 (release bounce; no new pulse).
    - Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE.
    - Else cnt=cnt+1.
- enable_pulse:
  - Registered. High for exactly one cycle: the first cycle in HELD.
  - Cleared at the next edge unconditionally.
  - Never asserted on release.
- Latency: with raw_in rising before edge 1 and staying stable, enable_pulse is high between edge SYNC_STAGES+1+DEBOUNCE_CYCLES and the following edge.
  - Defaults (2, 16): pulse high between edges 19 and 20.
- Release latency: level_out falls SYNC_STAGES+1+DEBOUNCE_CYCLES edges after raw_in falls, assuming it stays stable.
- Counter arithmetic:
  - cnt is unsigned CNT_W bits and never exceeds DEBOUNCE_CYCLES-1, so it never wraps.
  - cnt is reset to 0 on every state entry.
- DEBOUNCE_CYCLES=1: PRESS_WAIT lasts exactly one edge. s must be 1 at that edge for the press to be accepted.
- Minimum spacing between two accepted presses is 2*(DEBOUNCE_CYCLES+1) cycles. Faster toggling is filtered and never produces extra pulses.
- Reset mid-operation:
  - Asserting reset in any state aborts it; no pulse is emitted.
  - After release, if raw_in is still high, a full press sequence is required before a pulse. This holds even if the FSM was in HELD.
- Illegal or unused state encodings recover to IDLE with all outputs 0.

Decomposition:
- Shared package `debounce_pkg`:
  - State encoding localparams: IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3.
  - Constant function clog2 used for CNT_W.
- One sub-module, `bit_synchronizer`:
  - Parameter SYNC_STAGES.
  - Ports: clock, reset, d, q.
  - Reset is asynchronous, active-high, to 0.
- The FSM, counter and output registers live in `debounced_enable_gen`.

Test Plan:
- Reset: hold reset 3 cycles with raw_in=1, then release -> all outputs 0 during reset. First pulse arrives exactly SYNC_STAGES+1+DEBOUNCE_CYCLES edges after release (defaults: edge 19).
- Clean press: raw_in 0→1 before edge 1, held 100 cycles (defaults) -> exactly one enable_pulse, high between edges 19 and 20. level_out=1 from edge 19; busy=1 between edges 3 and 19.
- Press bounce: raw_in high 5 cycles, low 3, high 5, low (DEBOUNCE_CYCLES=16) -> zero pulses, level_out stays 0, FSM returns to IDLE.
- Release bounce: after an accepted press, raw_in toggles 1/0 every 3 cycles for 30 cycles, then stays 0 -> no second pulse. level_out falls only after 16 consecutive low synchronised cycles.
- Reset mid-PRESS_WAIT: raw_in high, assert reset at cycle 10, release at cycle 12 with raw_in still high -> no pulse before cycle 12+19. Exactly one pulse afterwards.
- Counter chain: feed 5 clean presses spaced 60 cycles into the downstream 4-bit counter enable -> counter reads 5; enable_pulse count equals 5.
